// File: rtl/mul_round_pack.sv
// Rounding and packing back end of a single-precision multiplier.
// S1 applies the selected rounding mode; S2 computes the final exponent and packs result and flags.
module mul_round_pack (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] norm_mant,
  input  logic        sticky_in,
  input  logic [4:0]  shl,
  input  logic        ovf,
  input  logic [9:0]  ez_add,
  input  logic        den_in,
  input  logic        sign_in,
  input  logic [1:0]  special_in,
  input  logic [1:0]  rnd_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;

  logic        s1_valid_reg;
  logic [24:0] s1_m25_reg;
  logic        s1_inexact_reg;
  logic        s1_sign_reg;
  logic [1:0]  s1_special_reg;
  logic [9:0]  s1_ez_reg;
  logic [4:0]  s1_shl_reg;
  logic        s1_ovf_reg;
  logic        s1_den_reg;
  logic [1:0]  s1_rnd_reg;

  logic        out_valid_reg;
  logic [31:0] result_reg;
  logic [2:0]  flags_reg;

  logic        s1_load;
  logic        s2_load;
  logic        inc;
  logic        guard_bit;
  logic        inexact_next;
  logic [24:0] m25_next;
  logic [10:0] exp_sum;
  logic [22:0] mant_field;
  logic        ovf_to_inf;
  logic [31:0] result_next;
  logic [2:0]  flags_next;

  // S2 empties into the output on out_ready; S1 can refill whenever S2 can take its contents.
  assign s2_load  = ~out_valid_reg | out_ready;
  assign s1_load  = ~s1_valid_reg | s2_load;
  assign in_ready = s1_load;

  assign guard_bit    = norm_mant[0];
  assign inexact_next = guard_bit | sticky_in;

  always_comb begin
    inc = 1'b0;
    case (rnd_mode)
      RM_RNE:  inc = guard_bit & (sticky_in | norm_mant[1]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign_in & inexact_next;
      default: inc = sign_in & inexact_next;
    endcase
  end

  assign m25_next = {1'b0, norm_mant[24:1]} + {24'b0, inc};

  // Bit 24 of the rounded mantissa means rounding carried out: bump exponent, clear fraction.
  assign exp_sum    = {s1_ez_reg[9], s1_ez_reg} + {10'b0, s1_ovf_reg}
                    - {6'b0, s1_shl_reg} + {10'b0, s1_m25_reg[24]};
  assign mant_field = s1_m25_reg[24] ? 23'b0 : s1_m25_reg[22:0];
  assign ovf_to_inf = (s1_rnd_reg == RM_RNE) |
                      ((s1_rnd_reg == RM_RUP) & ~s1_sign_reg) |
                      ((s1_rnd_reg == RM_RDN) & s1_sign_reg);

  always_comb begin
    result_next = 32'b0;
    flags_next  = 3'b000;
    if (s1_special_reg == SP_NORMAL) begin
      if (s1_den_reg) begin
        result_next = {s1_sign_reg, 7'b0, s1_m25_reg[23], s1_m25_reg[22:0]};
        flags_next  = {1'b0, s1_inexact_reg, s1_inexact_reg};
      end else if ($signed(exp_sum) >= 11'sd255) begin
        result_next = ovf_to_inf ? {s1_sign_reg, 8'hFF, 23'h000000}
                                 : {s1_sign_reg, 8'hFE, 23'h7FFFFF};
        flags_next  = 3'b101;
      end else if ($signed(exp_sum) <= 11'sd0) begin
        result_next = {s1_sign_reg, 31'b0};
        flags_next  = 3'b011;
      end else begin
        result_next = {s1_sign_reg, exp_sum[7:0], mant_field};
        flags_next  = {2'b00, s1_inexact_reg};
      end
    end else if (s1_special_reg == SP_ZERO) begin
      result_next = {s1_sign_reg, 31'b0};
    end else if (s1_special_reg == SP_INF) begin
      result_next = {s1_sign_reg, 8'hFF, 23'b0};
    end else begin
      result_next = 32'h7FC00000;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_reg   <= 1'b0;
      s1_m25_reg     <= 25'b0;
      s1_inexact_reg <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_special_reg <= 2'b0;
      s1_ez_reg      <= 10'b0;
      s1_shl_reg     <= 5'b0;
      s1_ovf_reg     <= 1'b0;
      s1_den_reg     <= 1'b0;
      s1_rnd_reg     <= 2'b0;
      out_valid_reg  <= 1'b0;
      result_reg     <= 32'b0;
      flags_reg      <= 3'b0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_m25_reg     <= m25_next;
          s1_inexact_reg <= inexact_next;
          s1_sign_reg    <= sign_in;
          s1_special_reg <= special_in;
          s1_ez_reg      <= ez_add;
          s1_shl_reg     <= shl;
          s1_ovf_reg     <= ovf;
          s1_den_reg     <= den_in;
          s1_rnd_reg     <= rnd_mode;
        end
      end
      if (s2_load) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          result_reg <= result_next;
          flags_reg  <= flags_next;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_mul_round_pack.sv
// Self-checking bench for mul_round_pack: directed vectors, backpressure, reset in flight
// and random products checked through an expected-result queue.
module tb_mul_round_pack;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] norm_mant;
  logic        sticky_in;
  logic [4:0]  shl;
  logic        ovf;
  logic [9:0]  ez_add;
  logic        den_in;
  logic        sign_in;
  logic [1:0]  special_in;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [34:0] sb[$];

  mul_round_pack dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .norm_mant(norm_mant), .sticky_in(sticky_in), .shl(shl), .ovf(ovf),
    .ez_add(ez_add), .den_in(den_in), .sign_in(sign_in), .special_in(special_in),
    .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: integer rounding of the 24-bit significand, then exponent range handling.
  function automatic logic [34:0] model(input logic [24:0] nm, input logic st,
                                        input logic [4:0] sh, input logic ov,
                                        input logic [9:0] ez, input logic dn,
                                        input logic sg, input logic [1:0] sp,
                                        input logic [1:0] rm);
    int mi, e;
    logic up, inex, to_inf;
    logic [31:0] r;
    logic [2:0] f;
    if (sp == 2'b01) return {sg, 31'b0, 3'b000};
    if (sp == 2'b10) return {sg, 8'hFF, 23'b0, 3'b000};
    if (sp == 2'b11) return {32'h7FC00000, 3'b000};
    inex = nm[0] | st;
    case (rm)
      2'b00:   up = nm[0] && (st || nm[1]);
      2'b01:   up = 1'b0;
      2'b10:   up = !sg && inex;
      default: up = sg && inex;
    endcase
    mi = int'(nm[24:1]) + (up ? 1 : 0);
    if (dn) begin
      r = {sg, 8'(mi >> 23), 23'(mi & 32'h7FFFFF)};
      f = {1'b0, inex, inex};
      return {r, f};
    end
    e = int'($signed(ez)) + (ov ? 1 : 0) - int'(sh);
    if (mi >= (1 << 24)) begin
      e = e + 1;
      mi = mi >> 1;
    end
    to_inf = (rm == 2'b00) || (rm == 2'b10 && !sg) || (rm == 2'b11 && sg);
    if (e >= 255) begin
      r = to_inf ? {sg, 8'hFF, 23'h0} : {sg, 8'hFE, 23'h7FFFFF};
      f = 3'b101;
    end else if (e <= 0) begin
      r = {sg, 31'b0};
      f = 3'b011;
    end else begin
      r = {sg, 8'(e), 23'(mi & 32'h7FFFFF)};
      f = {2'b00, inex};
    end
    return {r, f};
  endfunction

  // Scoreboard consumer: every output transfer is checked against the oldest expectation.
  always @(negedge CLK) begin
    if (RST && out_valid && out_ready) begin
      total++;
      n_out++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h/%b required=none", result, flags);
      end else begin
        logic [34:0] expv;
        expv = sb.pop_front();
        if ({result, flags} !== expv) begin
          bad++;
          $display("FAIL output got=%h/%b required=%h/%b", result, flags, expv[34:3], expv[2:0]);
        end else begin
          $display("out result=%h flags=%b", result, flags);
        end
      end
    end
  end

  task automatic drive(input logic [24:0] nm, input logic st, input logic [4:0] sh,
                       input logic ov, input logic [9:0] ez, input logic dn, input logic sg,
                       input logic [1:0] sp, input logic [1:0] rm);
    norm_mant = nm; sticky_in = st; shl = sh; ovf = ov; ez_add = ez;
    den_in = dn; sign_in = sg; special_in = sp; rnd_mode = rm;
    in_valid = 1'b1;
  endtask

  // Holds the product until accepted; pushes its expectation at the accepting edge.
  task automatic send(input logic [24:0] nm, input logic st, input logic [4:0] sh,
                      input logic ov, input logic [9:0] ez, input logic dn, input logic sg,
                      input logic [1:0] sp, input logic [1:0] rm, input logic [34:0] expv);
    bit done = 1'b0;
    drive(nm, st, sh, ov, ez, dn, sg, sp, rm);
    for (int i = 0; i < 50 && !done; i++) begin
      if (i > 3) out_ready = 1'b1;
      @(negedge CLK);
      if (in_ready) begin
        sb.push_back(expv);
        done = 1'b1;
        $display("in  mant=%h ez=%h rm=%0d sp=%0d exp=%h/%b", nm, ez, rm, sp, expv[34:3], expv[2:0]);
      end
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout got=in_ready_low required=accept");
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge CLK); #1;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout got=%0d_pending required=0", sb.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(25'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #3;
    total++;
    if ({in_ready, out_valid, result, flags} !== {1'b1, 1'b0, 32'b0, 3'b0}) begin
      bad++;
      $display("FAIL reset_state got=%b%b_%h_%b required=10_00000000_000", in_ready, out_valid, result, flags);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got=%b%b required=10", in_ready, out_valid);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    drive(25'h1800000, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b00);
    @(negedge CLK);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL latency_accept got=%b required=1", in_ready);
    end
    sb.push_back({32'h3FC00000, 3'b000});
    @(posedge CLK); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_cycle1 got=%b required=0", out_valid);
    end
    @(posedge CLK); #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_cycle2 got=%b required=1", out_valid);
    end
    wait_drain();
  endtask

  task automatic test_rounding();
    out_ready = 1'b1;
    send(25'h1000001, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b00, {32'h3F800000, 3'b001});
    send(25'h1000001, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b10, {32'h3F800001, 3'b001});
    send(25'h1FFFFFF, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b00, {32'h40000000, 3'b001});
    send(25'h1000000, 0, 0, 1, 10'd254, 0, 0, 2'b00, 2'b00, {32'h7F800000, 3'b101});
    send(25'h1000000, 0, 0, 1, 10'd254, 0, 0, 2'b00, 2'b01, {32'h7F7FFFFF, 3'b101});
    send(25'h1000000, 0, 0, 1, 10'd254, 0, 1, 2'b00, 2'b10, {32'hFF7FFFFF, 3'b101});
    send(25'h1000001, 1, 0, 0, 10'd127, 0, 1, 2'b00, 2'b11, {32'hBF800001, 3'b001});
    send(25'h1000000, 0, 5'd5, 0, 10'd1, 0, 1, 2'b00, 2'b00, {32'h80000000, 3'b011});
    send(25'h0FFFFFF, 0, 0, 0, 10'd0, 1, 0, 2'b00, 2'b00, {32'h00800000, 3'b011});
    send(25'h0000004, 0, 0, 0, 10'd0, 1, 0, 2'b00, 2'b00, {32'h00000002, 3'b000});
    wait_drain();
  endtask

  task automatic test_special();
    out_ready = 1'b1;
    send(25'h1FFFFFF, 1, 0, 0, 10'd127, 0, 1, 2'b01, 2'b00, {32'h80000000, 3'b000});
    send(25'h1FFFFFF, 1, 0, 0, 10'd127, 0, 0, 2'b10, 2'b00, {32'h7F800000, 3'b000});
    send(25'h1FFFFFF, 1, 0, 0, 10'd127, 0, 1, 2'b11, 2'b10, {32'h7FC00000, 3'b000});
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int start;
    start = n_out;
    out_ready = 1'b0;
    send(25'h1800000, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b00, {32'h3FC00000, 3'b000});
    send(25'h1FFFFFF, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b00, {32'h40000000, 3'b001});
    drive(25'h1000001, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'h3FC00000 || flags !== 3'b000) begin
        bad++;
        $display("FAIL hold got=rdy%b v%b %h/%b required=rdy0 v1 3fc00000/000",
                 in_ready, out_valid, result, flags);
      end
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    send(25'h1000001, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b10, {32'h3F800001, 3'b001});
    wait_drain();
    total++;
    if (n_out - start !== 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=3", n_out - start);
    end
  endtask

  task automatic test_reset_flight();
    int start;
    out_ready = 1'b0;
    send(25'h1800000, 0, 0, 0, 10'd127, 0, 0, 2'b00, 2'b00, {32'h3FC00000, 3'b000});
    send(25'h1800000, 0, 0, 0, 10'd128, 0, 0, 2'b00, 2'b00, {32'h40400000, 3'b000});
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL flight_full got=%b required=1", out_valid);
    end
    #2 RST = 1'b0;
    #1;
    sb.delete();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flight_reset got=v%b rdy%b required=v0 rdy1", out_valid, in_ready);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    out_ready = 1'b1;
    start = n_out;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flight_ghost got=%b required=0", out_valid);
      end
    end
    send(25'h1000000, 0, 0, 0, 10'd127, 0, 1, 2'b00, 2'b00, {32'hBF800000, 3'b000});
    wait_drain();
    total++;
    if (n_out - start !== 1) begin
      bad++;
      $display("FAIL flight_count got=%0d required=1", n_out - start);
    end
  endtask

  task automatic test_random();
    logic [24:0] nm;
    logic st, ov, dn, sg;
    logic [4:0] sh;
    logic [9:0] ez;
    logic [1:0] rm;
    for (int i = 0; i < 40; i++) begin
      dn = ($urandom_range(0, 4) == 0);
      nm = dn ? {1'b0, 24'($urandom)} : {1'b1, 24'($urandom)};
      st = 1'($urandom);
      sh = dn ? 5'd0 : 5'($urandom_range(0, 24));
      ov = dn ? 1'b0 : 1'($urandom);
      ez = dn ? 10'd0 : 10'($urandom_range(0, 290));
      sg = 1'($urandom);
      rm = 2'($urandom);
      out_ready = 1'($urandom);
      send(nm, st, sh, ov, ez, dn, sg, 2'b00, rm, model(nm, st, sh, ov, ez, dn, sg, 2'b00, rm));
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_special();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_round_pack.md
MUL_ROUND_PACK -- requirements
Module: mul_round_pack

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, asynchronous, active-low; clears all state immediately on assertion.
REQ-003 in_valid  in  1  upstream normalizer presents a valid product.
REQ-004 in_ready  out  1  block accepts the product this cycle (transfer = in_valid & in_ready).
REQ-005 norm_mant  in  25  hidden bit [24], mantissa [23:1], guard bit [0].
REQ-006 sticky_in  in  1  OR of all product bits below guard.
REQ-007 shl  in  5  left-shift count applied by the normalizer (0..24).
REQ-008 ovf  in  1  product was in [2,4); exponent +1.
REQ-009 ez_add  in  10  biased exponent sum, two's complement.
REQ-010 den_in  in  1  denormal path; norm_mant already right-shifted, exponent field 0.
REQ-011 sign_in  in  1  result sign.
REQ-012 special_in  in  2  00 normal, 01 zero, 10 infinity, 11 qNaN.
REQ-013 rnd_mode  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf); sampled with the product.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 result  out  32  IEEE-754 single.
REQ-017 flags  out  3  {overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-018 Two register stages S1 (round) and S2 (exponent/pack); latency exactly 2 cycles from accept to out_valid when out_ready stays high; throughput 1 per cycle.
REQ-019 A stage loads when empty or when its contents move on this cycle; in_ready = ~S1_valid | (~S2_valid | out_ready).
REQ-020 With out_valid=1 and out_ready=0, result, flags and out_valid remain stable; no product is lost or duplicated.
REQ-021 S1: inc = RNE: g&(sticky|lsb); RTZ: 0; RUP: ~sign&(g|sticky); RDN: sign&(g|sticky); g=norm_mant[0], lsb=norm_mant[1].
REQ-022 S1: m25 = {1'b0,norm_mant[24:1]} + inc; inexact = g|sticky_in.
REQ-023 S2 normal path: E (11-bit signed) = sext(ez_add) + ovf - shl + m25[24]; mantissa field = m25[24] ? 0 : m25[22:0].
REQ-024 E >= 255: overflow=1, inexact=1; result = inf for RNE, for RUP when sign=0, for RDN when sign=1; otherwise max finite (exp 254, mantissa all ones).
REQ-025 E <= 0 on normal path: result = signed zero, underflow=1, inexact=1.
REQ-026 den_in=1: exponent field = m25[23] (rounding into hidden bit yields exp 1); underflow = inexact.
REQ-027 special_in != 00 bypasses rounding: zero -> {sign,31'b0}; inf -> {sign,8'hFF,23'b0}; qNaN -> 32'h7FC00000; flags 0.
REQ-028 Simultaneous S2 drain and S1 load in the same cycle is legal and required for full throughput.

Reset
REQ-029 On RST low: S1_valid=S2_valid=0, out_valid=0, result=0, flags=0; in_ready=1 while RST is low and in the first cycle after release.
REQ-030 A product in flight when reset asserts is discarded; no out_valid pulse follows release.

Verification
REQ-031 norm_mant=25'h1800000, sticky 0, ez_add=127, shl 0, ovf 0, RNE -> result 32'h3FC00000, flags 000, 2 cycles later.
REQ-032 norm_mant=25'h1000001, sticky 0, ez_add=127: RNE -> 32'h3F800000, inexact; RUP -> 32'h3F800001, inexact.
REQ-033 norm_mant=25'h1FFFFFF, sticky 0, ez_add=127, RNE -> mantissa carry, result 32'h40000000, inexact.
REQ-034 ez_add=254, ovf=1, sign 0: RNE -> 32'h7F800000, flags 101; RTZ -> 32'h7F7FFFFF, flags 101.
REQ-035 Three back-to-back products with out_ready=0 -> in_ready drops after two accepts, output holds the first; raising out_ready drains all three in order, no loss.
REQ-036 Assert RST with both stages full -> out_valid falls immediately, stays 0 after release until a new product is accepted.
